// File: rtl/vram_arbiter.sv
// Video SRAM arbiter. Channel 0 (screen fetch) has fixed priority and the other
// channels share the bus round-robin. Each access is a fixed-length strobe window.
module vram_arbiter #(
  parameter int NCH        = 3,
  parameter int AW         = 19,
  parameter int DW         = 8,
  parameter int ACC_CYC    = 2,
  parameter int WR_RECOVER = 1
) (
  input  logic              clk28,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  input  logic [DW-1:0]     vd,
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     rdata,
  output logic [NCH-1:0]    rvalid,
  output logic [AW-1:0]     va,
  output logic [DW-1:0]     vd_out,
  output logic              vd_oe,
  output logic              n_vrd,
  output logic              n_vwr,
  output logic              busy
);
  localparam int CHW = $clog2(NCH);
  localparam int CW  = $clog2(ACC_CYC) + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [CHW-1:0] win;
  logic [CHW-1:0] rr_ptr;
  logic [CHW-1:0] grant;
  logic           lat_we;
  logic [AW-1:0]  lat_addr;
  logic [DW-1:0]  lat_wdata;
  logic [NCH-1:0] ack_q;
  logic [NCH-1:0] rvalid_q;
  logic [DW-1:0]  rdata_q;
  logic           last_cyc;
  logic           in_acc;

  logic [AW-1:0]  addr_ch  [NCH];
  logic [DW-1:0]  wdata_ch [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign addr_ch[i]  = addr[i*AW +: AW];
    assign wdata_ch[i] = wdata[i*DW +: DW];
  end

  assign last_cyc = (cnt == CW'(ACC_CYC - 1));
  assign in_acc   = (state == ACCESS);

  // Channel 0 wins outright; otherwise the lowest rotation offset from rr_ptr wins.
  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin : arbitrate
    logic [CHW-1:0] cand;
    grant = '0;
    cand  = '0;
    if (!req[0]) begin
      for (int k = NCH - 2; k >= 0; k--) begin
        cand = CHW'(1 + ((int'(rr_ptr) - 1 + k) % (NCH - 1)));
        if (req[cand]) grant = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ACCESS;
      ACCESS:  if (last_cyc) state_nxt = (lat_we && WR_RECOVER != 0) ? RECOVER : IDLE;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      win       <= '0;
      rr_ptr    <= CHW'(1);
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ack_q     <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      ack_q    <= '0;
      rvalid_q <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            win       <= grant;
            cnt       <= '0;
            lat_we    <= we[grant];
            lat_addr  <= addr_ch[grant];
            lat_wdata <= wdata_ch[grant];
            if (grant != '0) rr_ptr <= (grant == CHW'(NCH - 1)) ? CHW'(1) : grant + 1'b1;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (last_cyc) begin
            ack_q[win] <= 1'b1;
            if (!lat_we) begin
              rvalid_q[win] <= 1'b1;
              rdata_q       <= vd;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so reset releases them without waiting for a clock.
  assign va     = lat_addr;
  assign vd_out = lat_wdata;
  assign vd_oe  = in_acc && lat_we;
  assign n_vrd  = !(in_acc && !lat_we);
  assign n_vwr  = !(in_acc && lat_we && (ACC_CYC == 1 || cnt != '0));
  assign busy   = (state != IDLE);
  assign ack    = ack_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed scenarios for the VRAM arbiter plus a randomized run checked against a
// timestamp-level model (grant cycle -> access window -> ack cycle -> next free cycle).
module tb_vram_arbiter;
  localparam int NCH        = 3;
  localparam int AW         = 19;
  localparam int DW         = 8;
  localparam int ACC_CYC    = 2;
  localparam int WR_RECOVER = 1;

  logic              clk28 = 1'b0;
  logic              rst   = 1'b1;
  logic [NCH-1:0]    req   = '0;
  logic [NCH-1:0]    we    = '0;
  logic [NCH*AW-1:0] addr  = '0;
  logic [NCH*DW-1:0] wdata = '0;
  logic [DW-1:0]     vd    = '0;
  logic [NCH-1:0]    ack;
  logic [DW-1:0]     rdata;
  logic [NCH-1:0]    rvalid;
  logic [AW-1:0]     va;
  logic [DW-1:0]     vd_out;
  logic              vd_oe;
  logic              n_vrd;
  logic              n_vwr;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk28 = ~clk28;

  vram_arbiter #(
    .NCH(NCH), .AW(AW), .DW(DW), .ACC_CYC(ACC_CYC), .WR_RECOVER(WR_RECOVER)
  ) dut (
    .clk28(clk28), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .vd(vd),
    .ack(ack), .rdata(rdata), .rvalid(rvalid), .va(va), .vd_out(vd_out),
    .vd_oe(vd_oe), .n_vrd(n_vrd), .n_vwr(n_vwr), .busy(busy)
  );

  task automatic clear_inputs();
    req = '0; we = '0; addr = '0; wdata = '0; vd = '0;
  endtask

  // Leaves the bench on a negedge with rst low; the next posedge is the first live edge.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk28);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '1; we = 3'b101; addr = '1; wdata = '1; vd = 8'hFF;
    repeat (3) @(negedge clk28);
    checks++;
    if ({ack, rvalid, rdata, va, vd_out} !== '0) begin
      failures++;
      $display("FAIL reset_data: ack=%b rvalid=%b rdata=%h va=%h vd_out=%h, required all zero",
               ack, rvalid, rdata, va, vd_out);
    end
    checks++;
    if ({busy, vd_oe, n_vrd, n_vwr} !== 4'b0011) begin
      failures++;
      $display("FAIL reset_ctrl: busy/vd_oe/n_vrd/n_vwr=%b, required 0011", {busy, vd_oe, n_vrd, n_vwr});
    end
    req = 3'b010; we = '0; addr = '0; wdata = '0; addr[AW +: AW] = 19'h00ABC;
    rst = 1'b0;
    @(negedge clk28);
    checks++;
    if ({busy, n_vrd} !== 2'b10 || va !== 19'h00ABC) begin
      failures++;
      $display("FAIL reset_first_arb: busy=%b n_vrd=%b va=%h, required busy=1 n_vrd=0 va=00abc",
               busy, n_vrd, va);
    end
    req = '0;
    repeat (4) @(negedge clk28);
  endtask

  task automatic test_single_read();
    do_reset();
    req = 3'b010; addr[AW +: AW] = 19'h12345; vd = 8'hA5;
    for (int i = 0; i < ACC_CYC; i++) begin
      @(negedge clk28);
      checks++;
      if ({n_vrd, n_vwr, vd_oe, busy} !== 4'b0101 || va !== 19'h12345 || ack !== '0) begin
        failures++;
        $display("FAIL read_access[%0d]: n_vrd/n_vwr/vd_oe/busy=%b va=%h ack=%b, required 0101 va=12345 ack=000",
                 i, {n_vrd, n_vwr, vd_oe, busy}, va, ack);
      end
    end
    @(negedge clk28);
    checks++;
    if (ack !== 3'b010 || rvalid !== 3'b010 || rdata !== 8'hA5 || n_vrd !== 1'b1) begin
      failures++;
      $display("FAIL read_ack: ack=%b rvalid=%b rdata=%h n_vrd=%b, required 010 010 a5 1",
               ack, rvalid, rdata, n_vrd);
    end
    req = '0;
    @(negedge clk28);
    checks++;
    if (busy !== 1'b0 || ack !== '0 || rdata !== 8'hA5) begin
      failures++;
      $display("FAIL read_after: busy=%b ack=%b rdata=%h, required 0 000 a5", busy, ack, rdata);
    end
  endtask

  task automatic test_priority();
    do_reset();
    req = 3'b101; addr[0 +: AW] = 19'h00100; addr[2*AW +: AW] = 19'h00200; vd = 8'h11;
    @(negedge clk28);
    checks++;
    if (va !== 19'h00100 || n_vrd !== 1'b0) begin
      failures++;
      $display("FAIL prio_first: va=%h n_vrd=%b, required 00100 0", va, n_vrd);
    end
    repeat (ACC_CYC) @(negedge clk28);
    checks++;
    if (ack !== 3'b001 || rdata !== 8'h11) begin
      failures++;
      $display("FAIL prio_ack0: ack=%b rdata=%h, required 001 11", ack, rdata);
    end
    req[0] = 1'b0; vd = 8'h22;
    @(negedge clk28);
    checks++;
    if (va !== 19'h00200 || n_vrd !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL prio_second: va=%h n_vrd=%b busy=%b, required 00200 0 1", va, n_vrd, busy);
    end
    repeat (ACC_CYC) @(negedge clk28);
    checks++;
    if (ack !== 3'b100 || rvalid !== 3'b100 || rdata !== 8'h22) begin
      failures++;
      $display("FAIL prio_ack2: ack=%b rvalid=%b rdata=%h, required 100 100 22", ack, rvalid, rdata);
    end
    req = '0;
    repeat (3) @(negedge clk28);
  endtask

  task automatic test_round_robin();
    int exp_order [4];
    int n;
    logic [NCH-1:0] exp_ack;
    exp_order = '{1, 2, 1, 2};
    n = 0;
    do_reset();
    req = 3'b110;
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      @(negedge clk28);
      if (ack != '0) begin
        exp_ack = '0;
        exp_ack[exp_order[n]] = 1'b1;
        checks++;
        if (ack !== exp_ack) begin
          failures++;
          $display("FAIL rr_order #%0d: ack=%b, required %b", n, ack, exp_ack);
        end
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL rr_count: saw %0d acks within 40 cycles, required 4", n);
    end
    req = '0;
    repeat (4) @(negedge clk28);
  endtask

  task automatic test_write_recover();
    do_reset();
    req = 3'b100; we = 3'b100; addr[2*AW +: AW] = 19'h7FFFF; wdata[2*DW +: DW] = 8'h3C;
    @(negedge clk28);
    checks++;
    if ({vd_oe, n_vwr, n_vrd, busy} !== 4'b1111 || va !== 19'h7FFFF || vd_out !== 8'h3C) begin
      failures++;
      $display("FAIL wr_cyc1: vd_oe/n_vwr/n_vrd/busy=%b va=%h vd_out=%h, required 1111 7ffff 3c",
               {vd_oe, n_vwr, n_vrd, busy}, va, vd_out);
    end
    we = '0; addr[2*AW +: AW] = 19'h00001; wdata[2*DW +: DW] = 8'hFF;
    @(negedge clk28);
    checks++;
    if ({vd_oe, n_vwr, n_vrd, busy} !== 4'b1011 || va !== 19'h7FFFF || vd_out !== 8'h3C) begin
      failures++;
      $display("FAIL wr_cyc2: vd_oe/n_vwr/n_vrd/busy=%b va=%h vd_out=%h, required 1011 7ffff 3c",
               {vd_oe, n_vwr, n_vrd, busy}, va, vd_out);
    end
    @(negedge clk28);
    checks++;
    if (ack !== 3'b100 || rvalid !== '0 || {vd_oe, n_vwr, n_vrd, busy} !== 4'b0111 || rdata !== '0) begin
      failures++;
      $display("FAIL wr_recover: ack=%b rvalid=%b ctrl=%b rdata=%h, required 100 000 0111 00",
               ack, rvalid, {vd_oe, n_vwr, n_vrd, busy}, rdata);
    end
    req = '0;
    @(negedge clk28);
    checks++;
    if (busy !== 1'b0 || ack !== '0) begin
      failures++;
      $display("FAIL wr_idle: busy=%b ack=%b, required 0 000", busy, ack);
    end
  endtask

  task automatic test_mid_access_reset();
    int acks;
    do_reset();
    req = 3'b100; we = 3'b100; addr[2*AW +: AW] = 19'h055AA; wdata[2*DW +: DW] = 8'h5A;
    @(posedge clk28);
    #1;
    checks++;
    if (vd_oe !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_pre: vd_oe=%b busy=%b, required 1 1", vd_oe, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({n_vwr, n_vrd, vd_oe, busy} !== 4'b1100) begin
      failures++;
      $display("FAIL mid_reset_async: n_vwr/n_vrd/vd_oe/busy=%b, required 1100", {n_vwr, n_vrd, vd_oe, busy});
    end
    clear_inputs();
    repeat (2) @(negedge clk28);
    rst = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk28);
      if (ack != '0) acks++;
    end
    checks++;
    if (acks != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_noack: acks=%0d busy=%b, required 0 0", acks, busy);
    end
  endtask

  task automatic test_dropped_request();
    int acks0;
    int acks1;
    do_reset();
    req = 3'b001; addr[0 +: AW] = 19'h00010;
    @(negedge clk28);
    req[1] = 1'b1;
    @(negedge clk28);
    req[1] = 1'b0;
    acks0 = 0;
    acks1 = 0;
    repeat (8) begin
      @(negedge clk28);
      if (ack[0]) begin acks0++; req[0] = 1'b0; end
      if (ack[1]) acks1++;
    end
    checks++;
    if (acks0 != 1) begin
      failures++;
      $display("FAIL drop_ch0: ch0 acks=%0d, required 1", acks0);
    end
    checks++;
    if (acks1 != 0) begin
      failures++;
      $display("FAIL drop_ch1: ch1 acks=%0d, required 0", acks1);
    end
  endtask

  // Model: a grant at cycle g owns cycles g+1..g+ACC_CYC, acks at g+ACC_CYC+1, and the
  // arbiter is free again at the ack cycle (or one later after a write with recovery).
  task automatic test_random();
    int next_arb, acc_start, acc_end, ack_cyc, last_nz, win, ch;
    logic w_m;
    logic [AW-1:0] a_m;
    logic [DW-1:0] d_m, rdata_m;
    logic [NCH-1:0] exp_ack, exp_rv;
    logic in_acc, exp_busy, exp_oe, exp_vrd, exp_vwr;
    do_reset();
    next_arb = 0; acc_start = -100; acc_end = -100; ack_cyc = -100;
    last_nz = 0; win = 0; w_m = 1'b0; a_m = '0; d_m = '0; rdata_m = '0;
    for (int c = 0; c < 600; c++) begin
      in_acc   = (c >= acc_start) && (c <= acc_end);
      exp_busy = (c < next_arb);
      exp_oe   = in_acc && w_m;
      exp_vrd  = !(in_acc && !w_m);
      exp_vwr  = !(in_acc && w_m && (ACC_CYC == 1 || c != acc_start));
      exp_ack  = '0;
      exp_rv   = '0;
      if (c == ack_cyc) begin
        exp_ack[win] = 1'b1;
        exp_rv[win]  = !w_m;
      end
      checks++;
      if ({busy, vd_oe, n_vrd, n_vwr} !== {exp_busy, exp_oe, exp_vrd, exp_vwr}) begin
        failures++;
        $display("FAIL rnd_ctrl cyc=%0d: busy/vd_oe/n_vrd/n_vwr=%b, required %b",
                 c, {busy, vd_oe, n_vrd, n_vwr}, {exp_busy, exp_oe, exp_vrd, exp_vwr});
      end
      checks++;
      if (ack !== exp_ack || rvalid !== exp_rv || rdata !== rdata_m) begin
        failures++;
        $display("FAIL rnd_resp cyc=%0d: ack=%b rvalid=%b rdata=%h, required %b %b %h",
                 c, ack, rvalid, rdata, exp_ack, exp_rv, rdata_m);
      end
      if (in_acc) begin
        checks++;
        if (va !== a_m || (w_m && vd_out !== d_m)) begin
          failures++;
          $display("FAIL rnd_bus cyc=%0d: va=%h vd_out=%h, required va=%h vd_out=%h (write=%b)",
                   c, va, vd_out, a_m, d_m, w_m);
        end
      end

      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
        addr[i*AW +: AW]  = AW'($urandom);
        wdata[i*DW +: DW] = DW'($urandom);
      end
      we = NCH'($urandom);
      vd = DW'($urandom);

      if (c == acc_end && !w_m) rdata_m = vd;
      if (c >= next_arb && req != '0) begin
        if (req[0]) begin
          win = 0;
        end else begin
          win = -1;
          for (int k = 0; k < NCH - 1; k++) begin
            ch = ((last_nz + k) % (NCH - 1)) + 1;
            if (win < 0 && req[ch]) win = ch;
          end
          last_nz = win;
        end
        w_m       = we[win];
        a_m       = addr[win*AW +: AW];
        d_m       = wdata[win*DW +: DW];
        acc_start = c + 1;
        acc_end   = c + ACC_CYC;
        ack_cyc   = c + ACC_CYC + 1;
        next_arb  = ack_cyc + ((w_m && WR_RECOVER != 0) ? 1 : 0);
      end
      @(negedge clk28);
    end
    req = '0;
    repeat (6) @(negedge clk28);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_round_robin();
    test_write_recover();
    test_mid_access_reset();
    test_dropped_request();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Parameters
REQ-001 The module SHALL have parameter NCH, default 3, giving the number of requester channels (legal range 2..4).
REQ-002 The module SHALL have parameter AW, default 19, giving the SRAM address width.
REQ-003 The module SHALL have parameter DW, default 8, giving the SRAM data width.
REQ-004 The module SHALL have parameter ACC_CYC, default 2, giving the access length in clk28 cycles (legal range 1..4).
REQ-005 The module SHALL have parameter WR_RECOVER, default 1, which inserts one recovery cycle after every write when set to 1.

Interface
REQ-006 The module SHALL have the following ports (name, direction, width, meaning):
- clk28  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NCH  per-channel access request, level held until ack.
- we  in  NCH  per-channel write enable, qualified by req.
- addr  in  NCH*AW  per-channel address; channel i uses bits [i*AW +: AW].
- wdata  in  NCH*DW  per-channel write data.
- ack  out  NCH  one-cycle grant pulse, issued when the access completes.
- rdata  out  DW  read data, valid while rvalid is high.
- rvalid  out  NCH  one-cycle per-channel read-complete pulse, coincident with ack.
- va  out  AW  SRAM address.
- vd_out  out  DW  SRAM write data.
- vd_oe  out  1  SRAM data bus drive enable.
- n_vrd  out  1  SRAM read strobe, active low.
- n_vwr  out  1  SRAM write strobe, active low.
- busy  out  1  high in any state other than IDLE.
REQ-007 The clock and reset SHALL be exactly as follows: one clock, clk28; reset rst is asynchronous and active-high.

Function
REQ-008 The state machine SHALL have exactly three states: IDLE, ACCESS and RECOVER.
REQ-009 IDLE: when any req bit is high, the arbiter SHALL select a winner, register its addr, wdata and we, and enter ACCESS on the next clock edge.
REQ-010 Channel 0 (screen fetch) SHALL have fixed highest priority.
REQ-011 Channels 1..NCH-1 SHALL be arbitrated round-robin; the search starts at the channel after the last granted non-zero channel, and the pointer resets to channel 1.
REQ-012 ACCESS SHALL last exactly ACC_CYC cycles, counted by a cycle counter of width clog2(ACC_CYC)+1.
REQ-013 During ACCESS, va SHALL equal the latched address.
REQ-014 During a read ACCESS, n_vrd SHALL be 0 for all ACC_CYC cycles.
REQ-015 During a write ACCESS, n_vwr SHALL be 0 for all ACC_CYC cycles except the first, and vd_oe SHALL be 1 for all ACC_CYC cycles.
REQ-016 When ACC_CYC=1, n_vwr SHALL be 0 for that single cycle.
REQ-017 On the last ACCESS cycle of a read, the arbiter SHALL capture vd into the rdata register.
REQ-018 On the cycle after the last ACCESS cycle, the arbiter SHALL pulse ack[winner] and, for reads, rvalid[winner].
REQ-019 rdata SHALL hold its value until the next read completes.
REQ-020 After ACCESS, a write with WR_RECOVER=1 SHALL go to RECOVER; otherwise the arbiter SHALL go to IDLE.
REQ-021 RECOVER SHALL last 1 cycle with n_vwr=1 and vd_oe=0, then return to IDLE.
REQ-022 Back-to-back reads SHALL proceed with no bubble: arbitration is evaluated in the ack cycle (IDLE) and the next ACCESS starts the following cycle.
REQ-023 A request deasserted before its grant SHALL be dropped silently, with no ack.
REQ-024 Requests arriving while the arbiter is in ACCESS or RECOVER SHALL wait; ACCESS SHALL never be preempted, including by channel 0.
REQ-025 n_vrd and n_vwr SHALL never be low in the same cycle, and SHALL both be 1 in IDLE and RECOVER.
REQ-026 vd_oe SHALL be 0 whenever n_vrd=0.
REQ-027 A channel that keeps req high after its ack SHALL be treated as a new request.
REQ-028 Changes to the addr, wdata or we inputs during ACCESS SHALL have no effect on the access in progress.

Reset
REQ-029 While rst=1, the state SHALL be IDLE and the outputs SHALL be: ack=0, rvalid=0, rdata=0, va=0, vd_out=0, vd_oe=0, n_vrd=1, n_vwr=1, busy=0, round-robin pointer=1.
REQ-030 Reset asserted mid-ACCESS SHALL abort the access immediately (strobes go high asynchronously), and no ack SHALL be issued for it.
REQ-031 After rst deasserts, the first arbitration SHALL occur on the first clock edge with rst=0.

Verification
REQ-032 Single read: NCH=3, ACC_CYC=2, req[1]=1, we=0, addr1=0x12345, SRAM returns 0xA5 -> n_vrd low for 2 cycles with va=0x12345, then ack[1], rvalid[1] and rdata=0xA5 in the same cycle.
REQ-033 Priority: req[0] and req[2] raised in the same cycle -> channel 0 is granted first and channel 2 next, with no idle cycle between the two reads.
REQ-034 Round-robin: req[1] and req[2] held high continuously -> ack order is 1,2,1,2.
REQ-035 Write with recovery: ACC_CYC=2, WR_RECOVER=1, channel 2 writes 0x3C to 0x7FFFF -> vd_oe=1 for 2 cycles, n_vwr low in the 2nd cycle only, vd_out=0x3C, ack[2], one RECOVER cycle, then IDLE.
REQ-036 Mid-access reset: rst pulsed during the 1st ACCESS cycle of a write -> n_vwr=1 and vd_oe=0 immediately, no ack, busy=0.
REQ-037 Dropped request: req[1] pulsed for 1 cycle while channel 0 is in ACCESS -> ack[1] never asserts.
